// File: rtl/seq_match_logger.sv
// Match logger behind a 101101 sequence detector: counts qualified matches
// and buffers their stream bit positions in a FIFO drained by a read handshake.
module seq_match_logger #(
    parameter int POS_W = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_en,
    input  logic             match,
    input  logic             clear,
    input  logic             rd_en,
    output logic [POS_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] match_cnt,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = 1;
    localparam logic [AW:0]      OCC_ONE  = 1;
    localparam logic [AW:0]      OCC_FULL = DEPTH;
    localparam logic [POS_W-1:0] POS_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [POS_W-1:0] mem [0:DEPTH-1];
    logic [POS_W-1:0] bit_pos;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      occ;
    logic             hit;
    logic             pop;
    logic             push;
    logic             drop;

    assign empty = (occ == '0);
    assign full  = (occ == OCC_FULL);

    // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
    always_comb begin
        hit  = bit_en & match;
        pop  = rd_en & ~empty;
        push = hit & (~full | pop);
        drop = hit & full & ~pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_pos   <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            match_cnt <= '0;
            overflow  <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occ       <= '0;
        end else if (clear) begin
            bit_pos   <= '0;
            rd_valid  <= 1'b0;
            match_cnt <= '0;
            overflow  <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occ       <= '0;
        end else begin
            rd_valid <= pop;
            if (bit_en)
                bit_pos <= bit_pos + POS_ONE;
            if (hit && match_cnt != CNT_MAX)
                match_cnt <= match_cnt + CNT_ONE;
            if (drop)
                overflow <= 1'b1;
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (push && !pop)
                occ <= occ + OCC_ONE;
            else if (pop && !push)
                occ <= occ - OCC_ONE;
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr] <= bit_pos;
    end

endmodule
